// File: rtl/imem_boot_loader_if.sv
// Program-stream and instruction-memory write port bundle for imem_boot_loader.
// The slave side is the loader; the master side is the stream source and memory observer.
interface imem_boot_loader_if #(
    parameter int ADDR_W = 6
);
    logic              s_valid;
    logic              s_ready;
    logic [31:0]       s_data;
    logic              s_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output s_valid, s_data, s_last,
        input  s_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: streams a program into instruction memory, then releases the CPU
// from reset after a fixed delay. Overflowing the memory without a last marker is fatal.
module imem_boot_loader #(
    parameter int ADDR_W      = 6,
    parameter int RELEASE_DLY = 4
) (
    input  logic              clk,
    input  logic              rstn_in,
    imem_boot_loader_if.slave bus,
    output logic              cpu_rstn,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_cnt
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [7:0] dly_cnt;
    logic       hs;
    logic       at_top;

    assign hs     = bus.s_valid && bus.s_ready;
    assign at_top = (word_cnt == (ADDR_W+1)'(DEPTH - 1));

    // Status outputs follow the next state so they change exactly when the state does.
    always_ff @(posedge clk) begin
        if (!rstn_in) begin
            state     <= LOAD;
            cpu_rstn  <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            state     <= next_state;
            cpu_rstn  <= (next_state == RUN);
            load_done <= (next_state == RUN);
            load_err  <= (next_state == ERR);
        end
    end

    // HOLD waits one extra cycle after the counter hits zero, giving RELEASE_DLY+1 in total.
    always_comb begin
        next_state = state;
        case (state)
            LOAD: begin
                if (hs) begin
                    if (bus.s_last) begin
                        next_state = HOLD;
                    end else if (at_top) begin
                        next_state = ERR;
                    end
                end
            end
            HOLD: begin
                if (dly_cnt == 8'd0) begin
                    next_state = RUN;
                end
            end
            default: next_state = state;
        endcase
    end

    always_comb begin
        bus.s_ready = (state == LOAD);
    end

    always_ff @(posedge clk) begin
        if (!rstn_in) begin
            word_cnt       <= '0;
            dly_cnt        <= 8'd0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= 32'd0;
        end else begin
            bus.imem_we <= hs;
            if (hs) begin
                bus.imem_addr  <= word_cnt[ADDR_W-1:0];
                bus.imem_wdata <= bus.s_data;
                word_cnt       <= word_cnt + (ADDR_W+1)'(1);
            end
            if (hs && bus.s_last) begin
                dly_cnt <= 8'(RELEASE_DLY);
            end else if ((state == HOLD) && (dly_cnt != 8'd0)) begin
                dly_cnt <= dly_cnt - 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: a driver updates a phase-level model and queues
// expected memory writes; a negedge monitor compares every DUT output against it.
module tb_imem_boot_loader;
    localparam int AW    = 2;
    localparam int DLY   = 4;
    localparam int DEPTH = 1 << AW;

    typedef enum {M_LOAD, M_HOLD, M_RUN, M_ERR} mode_t;
    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rstn_in;
    logic        cpu_rstn;
    logic        load_done;
    logic        load_err;
    logic [AW:0] word_cnt;

    imem_boot_loader_if #(.ADDR_W(AW)) bus ();

    imem_boot_loader #(
        .ADDR_W     (AW),
        .RELEASE_DLY(DLY)
    ) dut (
        .clk      (clk),
        .rstn_in  (rstn_in),
        .bus      (bus.slave),
        .cpu_rstn (cpu_rstn),
        .load_done(load_done),
        .load_err (load_err),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    wr_t   expWrites[$];
    mode_t mode       = M_LOAD;
    int    wordsTaken = 0;
    int    waitLeft   = 0;
    bit    armed      = 1'b0;
    bit    justReset  = 1'b0;
    int    total      = 0;
    int    bad        = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model advances on the same edge the DUT samples.
    task automatic applyStimulus(input bit rst, input bit v, input logic [31:0] d, input bit l);
        wr_t w;
        rstn_in     = !rst;
        bus.s_valid = v;
        bus.s_data  = d;
        bus.s_last  = l;
        @(posedge clk);
        justReset = 1'b0;
        if (rst) begin
            mode       = M_LOAD;
            wordsTaken = 0;
            waitLeft   = 0;
            justReset  = 1'b1;
            armed      = 1'b1;
        end else if (mode == M_LOAD && v) begin
            w.addr = AW'(wordsTaken);
            w.data = d;
            expWrites.push_back(w);
            wordsTaken++;
            if (l) begin
                mode     = M_HOLD;
                waitLeft = DLY + 1;
            end else if (wordsTaken == DEPTH) begin
                mode = M_ERR;
            end
        end else if (mode == M_HOLD) begin
            waitLeft--;
            if (waitLeft == 0) mode = M_RUN;
        end
        #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic sendWord(input logic [31:0] d, input bit l);
        applyStimulus(1'b0, 1'b1, d, l);
    endtask

    task automatic pulseReset(input bit withValid);
        applyStimulus(1'b1, withValid, $urandom, 1'b0);
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (armed) begin
            checkOutput("cpu_rstn", 64'(cpu_rstn), 64'(mode == M_RUN));
            checkOutput("load_done", 64'(load_done), 64'(mode == M_RUN));
            checkOutput("load_err", 64'(load_err), 64'(mode == M_ERR));
            checkOutput("s_ready", 64'(bus.s_ready), 64'(mode == M_LOAD));
            checkOutput("word_cnt", 64'(word_cnt), 64'(wordsTaken));
            if (justReset) begin
                checkOutput("reset_imem_addr", 64'(bus.imem_addr), 64'd0);
                checkOutput("reset_imem_wdata", 64'(bus.imem_wdata), 64'd0);
            end
            checkOutput("imem_we", 64'(bus.imem_we), 64'(expWrites.size() != 0));
            if (expWrites.size() != 0) begin
                e = expWrites.pop_front();
                if (bus.imem_we) begin
                    checkOutput("imem_addr", 64'(bus.imem_addr), 64'(e.addr));
                    checkOutput("imem_wdata", 64'(bus.imem_wdata), 64'(e.data));
                end
            end
        end
    end

    initial begin
        int len;
        bit aborted;

        $display("[TB] basic three-word load");
        pulseReset(1'b0);
        sendWord(32'h2008_0005, 1'b0);
        sendWord(32'h2009_0003, 1'b0);
        sendWord(32'h0109_5020, 1'b1);
        idle(8);

        $display("[TB] bubbles between words");
        pulseReset(1'b0);
        sendWord(32'hAAAA_0001, 1'b0);
        idle(2);
        sendWord(32'hBBBB_0002, 1'b1);
        idle(7);

        $display("[TB] overflow without last");
        pulseReset(1'b0);
        for (int i = 0; i < DEPTH; i++) sendWord(32'hC000_0000 + 32'(i), 1'b0);
        sendWord(32'hDEAD_BEEF, 1'b1);
        sendWord(32'hDEAD_BEEF, 1'b0);
        idle(6);

        $display("[TB] exact fill with last");
        pulseReset(1'b0);
        for (int i = 0; i < DEPTH; i++) sendWord(32'hD000_0000 + 32'(i), i == DEPTH - 1);
        idle(7);

        $display("[TB] reset mid-load and in run");
        pulseReset(1'b0);
        sendWord(32'h1111_1111, 1'b0);
        sendWord(32'h2222_2222, 1'b0);
        pulseReset(1'b1);
        sendWord(32'h3333_3333, 1'b1);
        idle(7);
        pulseReset(1'b1);
        idle(2);

        $display("[TB] randomized programs");
        for (int t = 0; t < 40; t++) begin
            pulseReset($urandom_range(0, 1) == 1);
            len     = $urandom_range(1, DEPTH + 2);
            aborted = 1'b0;
            for (int i = 0; i < len && !aborted; i++) begin
                idle($urandom_range(0, 2));
                if ($urandom_range(0, 15) == 0) begin
                    pulseReset($urandom_range(0, 1) == 1);
                    aborted = 1'b1;
                end else begin
                    sendWord($urandom, (i == len - 1) && ($urandom_range(0, 3) != 0));
                end
            end
            for (int i = 0; i < DLY + 4; i++) begin
                applyStimulus(1'b0, $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 1) == 1);
            end
        end

        idle(2);
        checkOutput("writes_drained", 64'(expWrites.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/imem_boot_loader.md
IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

Interface
REQ-001 Parameter ADDR_W, default 6, width of the instruction-memory word address; depth DEPTH = 2^ADDR_W words.
REQ-002 Parameter RELEASE_DLY, default 4, number of cycles between the load completing and CPU reset release; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rstn_in  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 s_valid  input  1  program stream word valid.
REQ-006 s_ready  output  1  loader accepts a stream word this cycle.
REQ-007 s_data  input  32  instruction word.
REQ-008 s_last  input  1  marks the final word of the program.
REQ-009 imem_we  output  1  instruction-memory write strobe, one cycle per accepted word.
REQ-010 imem_addr  output  ADDR_W  instruction-memory word address.
REQ-011 imem_wdata  output  32  instruction-memory write data.
REQ-012 cpu_rstn  output  1  active-low reset to the CPU; 0 holds the CPU, 1 releases it.
REQ-013 load_done  output  1  program loaded and CPU released.
REQ-014 load_err  output  1  overflow error is latched.
REQ-015 word_cnt  output  ADDR_W+1  number of words accepted since reset.

Function
REQ-016 The loader SHALL implement the states LOAD, HOLD, RUN and ERR, all encoded and registered.
REQ-017 In LOAD, s_ready SHALL be 1; in HOLD, RUN and ERR, s_ready SHALL be 0.
REQ-018 A handshake SHALL occur on a rising edge where s_valid=1 and s_ready=1; when s_valid=0, the loader SHALL take no action.
REQ-019 For each handshake, the loader SHALL drive imem_we=1, imem_addr=word_cnt (value before increment) and imem_wdata=s_data in the cycle immediately following; imem_we SHALL be 0 in all other cycles (latency 1, registered).
REQ-020 The loader SHALL increment word_cnt by 1 per handshake; it SHALL never exceed DEPTH.
REQ-021 On a handshake with s_last=1, the loader SHALL go LOAD->HOLD and load the delay counter with RELEASE_DLY.
REQ-022 On a handshake with s_last=0 at address DEPTH-1 (memory full, no last), the loader SHALL still write the word, set word_cnt=DEPTH and go LOAD->ERR.
REQ-023 A handshake with s_last=1 at address DEPTH-1 SHALL be legal and SHALL go to HOLD, not ERR.
REQ-024 In HOLD, the loader SHALL decrement the delay counter each cycle and go HOLD->RUN on the cycle the counter reaches 0, so that cpu_rstn rises exactly RELEASE_DLY+1 cycles after the last handshake edge.
REQ-025 In RUN, cpu_rstn SHALL be 1 and load_done SHALL be 1; stream input SHALL be ignored; RUN SHALL persist until reset.
REQ-026 In ERR, cpu_rstn SHALL be 0, load_err SHALL be 1 and s_ready SHALL be 0; ERR SHALL persist until reset.
REQ-027 cpu_rstn SHALL be 0 in LOAD, HOLD and ERR; the output SHALL be registered and glitch-free.
REQ-028 An empty program (s_last never asserted) SHALL leave the CPU held in reset indefinitely; no timeout SHALL apply.

Reset
REQ-029 While rstn_in=0 at a rising edge, the loader SHALL enter LOAD, with word_cnt=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rstn=0, load_done=0, load_err=0, and the delay counter at 0.
REQ-030 Reset SHALL take priority over all other events, including a handshake in the same cycle; that word SHALL NOT be written.
REQ-031 Reset asserted in any state (mid-load, HOLD, RUN, ERR) SHALL re-hold the CPU (cpu_rstn=0) from the next edge and restart loading at address 0.

Verification
REQ-032 Basic load: 3 words 0x20080005, 0x20090003, 0x01095020 (last on the third), s_valid held high -> writes at addr 0,1,2 on consecutive cycles; word_cnt=3; cpu_rstn rises 5 cycles after the third handshake; load_done=1.
REQ-033 Bubbles: s_valid toggles 1,0,0,1(last) -> exactly 2 imem_we pulses, at addr 0 and 1, with no write during the idle cycles.
REQ-034 Overflow, ADDR_W=2: 4 words sent, none with last -> 4 writes at addr 0..3, then load_err=1, s_ready=0, word_cnt=4, cpu_rstn remains 0.
REQ-035 Exact fill, ADDR_W=2: 4 words sent, last on the fourth -> no error; load_done=1 after the delay.
REQ-036 Reset mid-operation: rstn_in=0 for one cycle after 2 words, then 1 word with last -> rewrite at addr 0, word_cnt=1, normal release. The same reset pulse applied in RUN -> cpu_rstn=0 on the next edge and s_ready=1.
